// File: rtl/scalar_divide_mat_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scalar_divide_mat_seq : matrix / scalar via one shared restoring divider |
// | Optional macro: SCALAR_DIV_ROUND_NEAREST_EN (round half away from zero)  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module scalar_divide_mat_seq #(
    parameter int SIZE_A    = 8,
    parameter int SIZE_B    = 8,
    parameter int N_BITS    = 22,
    parameter int FRAC_BITS = 0,
    parameter int SIGNED    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [N_BITS-1:0] scale_i,
    input  logic [N_BITS-1:0] matrix_i     [SIZE_A][SIZE_B],
    output logic [N_BITS-1:0] out_matrix_o [SIZE_A][SIZE_B],
    output logic              busy_o,
    output logic              done_o,
    output logic              div_zero_o,
    output logic              ovf_o
);
    localparam int Q  = N_BITS + FRAC_BITS;
    localparam int RW = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;
    localparam int CW = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
    localparam int KW = (Q > 1) ? $clog2(Q) : 1;

    localparam logic [RW-1:0]     C_LAST_ROW = RW'(SIZE_A - 1);
    localparam logic [CW-1:0]     C_LAST_COL = CW'(SIZE_B - 1);
    localparam logic [KW-1:0]     C_LAST_BIT = KW'(Q - 1);
    localparam logic [Q:0]        C_UMAX     = {{(FRAC_BITS + 1){1'b0}}, {N_BITS{1'b1}}};
    localparam logic [Q:0]        C_SMAX     = C_UMAX >> 1;
    localparam logic [Q:0]        C_SMIN_MAG = C_SMAX + (Q + 1)'(1);
    localparam logic [N_BITS-1:0] C_POS_SAT  = (SIGNED != 0) ? {1'b0, {(N_BITS - 1){1'b1}}}
                                                             : {N_BITS{1'b1}};
    localparam logic [N_BITS-1:0] C_NEG_SAT  = {1'b1, {(N_BITS - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic f_neg(input logic [N_BITS-1:0] v);
        return (SIGNED != 0) && v[N_BITS-1];
    endfunction

    // N-bit magnitude is exact even for the most negative operand (2^(N-1) fits unsigned).
    function automatic logic [N_BITS-1:0] f_mag(input logic [N_BITS-1:0] v);
        return f_neg(v) ? -v : v;
    endfunction

    state_t            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [KW-1:0]     cnt_q, cnt_d;
    logic [Q-1:0]      dq_q, dq_d;
    logic [N_BITS-1:0] rem_q, rem_d;
    logic              dneg_q, dneg_d;
    logic [N_BITS-1:0] smag_q;
    logic              sneg_q;
    logic              div_zero_q, ovf_q;
    logic [N_BITS-1:0] mat_q [SIZE_A][SIZE_B];
    logic [N_BITS-1:0] out_q [SIZE_A][SIZE_B];

    logic              w_accept, w_load, w_write, w_last, w_ge, w_sat;
    logic [N_BITS:0]   w_trial;
    logic [N_BITS-1:0] w_diff, w_ld_src, w_wval;
    logic [RW-1:0]     w_nrow;
    logic [CW-1:0]     w_ncol;
    logic [Q:0]        w_qmag;

    // dq_q shifts dividend bits out of the top while quotient bits enter at the bottom.
    assign w_trial = {rem_q, dq_q[Q-1]};
    assign w_ge    = (w_trial >= {1'b0, smag_q});
    assign w_diff  = w_trial[N_BITS-1:0] - smag_q;

`ifdef SCALAR_DIV_ROUND_NEAREST_EN
    logic w_round;
    assign w_round = ({rem_q, 1'b0} >= {1'b0, smag_q});
    assign w_qmag  = {1'b0, dq_q} + {{Q{1'b0}}, w_round};
`else
    assign w_qmag  = {1'b0, dq_q};
`endif

    assign w_last   = (row_q == C_LAST_ROW) && (col_q == C_LAST_COL);
    assign w_ncol   = (col_q == C_LAST_COL) ? '0 : col_q + CW'(1);
    assign w_nrow   = (col_q == C_LAST_COL) ? row_q + RW'(1) : row_q;
    assign w_ld_src = (state_q == S_IDLE) ? matrix_i[0][0] : mat_q[w_nrow][w_ncol];

    always_comb begin
        w_sat  = 1'b0;
        w_wval = w_qmag[N_BITS-1:0];
        if (SIGNED == 0) begin
            if (w_qmag > C_UMAX) begin
                w_sat  = 1'b1;
                w_wval = C_POS_SAT;
            end
        end else if (dneg_q ^ sneg_q) begin
            if (w_qmag > C_SMIN_MAG) begin
                w_sat  = 1'b1;
                w_wval = C_NEG_SAT;
            end else begin
                w_wval = -w_qmag[N_BITS-1:0];
            end
        end else if (w_qmag > C_SMAX) begin
            w_sat  = 1'b1;
            w_wval = C_POS_SAT;
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        cnt_d    = cnt_q;
        dq_d     = dq_q;
        rem_d    = rem_q;
        dneg_d   = dneg_q;
        w_accept = 1'b0;
        w_load   = 1'b0;
        w_write  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    w_accept = 1'b1;
                    row_d    = '0;
                    col_d    = '0;
                    if (scale_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DIV;
                        w_load  = 1'b1;
                    end
                end
            end
            S_DIV: begin
                dq_d  = {dq_q[Q-2:0], w_ge};
                rem_d = w_ge ? w_diff : w_trial[N_BITS-1:0];
                cnt_d = cnt_q + KW'(1);
                if (cnt_q == C_LAST_BIT) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                w_write = 1'b1;
                if (w_last) begin
                    state_d = S_DONE;
                end else begin
                    row_d   = w_nrow;
                    col_d   = w_ncol;
                    w_load  = 1'b1;
                    state_d = S_DIV;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (w_load) begin
            dq_d   = Q'(f_mag(w_ld_src)) << FRAC_BITS;
            rem_d  = '0;
            cnt_d  = '0;
            dneg_d = f_neg(w_ld_src);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            cnt_q      <= '0;
            dq_q       <= '0;
            rem_q      <= '0;
            dneg_q     <= 1'b0;
            smag_q     <= '0;
            sneg_q     <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < SIZE_A; i++) begin
                for (int j = 0; j < SIZE_B; j++) begin
                    out_q[i][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            dq_q    <= dq_d;
            rem_q   <= rem_d;
            dneg_q  <= dneg_d;
            if (w_accept) begin
                smag_q     <= f_mag(scale_i);
                sneg_q     <= f_neg(scale_i);
                div_zero_q <= (scale_i == '0);
                ovf_q      <= 1'b0;
                for (int i = 0; i < SIZE_A; i++) begin
                    for (int j = 0; j < SIZE_B; j++) begin
                        out_q[i][j] <= (scale_i == '0) ? C_POS_SAT : '0;
                    end
                end
            end else if (w_write) begin
                out_q[row_q][col_q] <= w_wval;
                if (w_sat) begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    // Operand snapshot needs no reset: it is only read during a run that loaded it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            mat_q <= matrix_i;
        end
    end

    assign out_matrix_o = out_q;
    assign busy_o       = (state_q == S_DIV) || (state_q == S_WRITE);
    assign done_o       = (state_q == S_DONE);
    assign div_zero_o   = div_zero_q;
    assign ovf_o        = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_scalar_divide_mat_seq.sv
`default_nettype none
// Bench for scalar_divide_mat_seq: three 2x2 8-bit configurations (unsigned, signed, FRAC_BITS=4)
// checked every cycle against an arithmetic model, plus hand-computed literal results.
module tb_scalar_divide_mat_seq;
    localparam int E = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       st   [3];
    logic [7:0] sc   [3];
    logic       busy [3];
    logic       done [3];
    logic       dz   [3];
    logic       ov   [3];
    logic [7:0] mat0 [2][2];
    logic [7:0] mat1 [2][2];
    logic [7:0] mat2 [2][2];
    logic [7:0] out0 [2][2];
    logic [7:0] out1 [2][2];
    logic [7:0] out2 [2][2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    scalar_divide_mat_seq #(.SIZE_A(2), .SIZE_B(2), .N_BITS(8), .FRAC_BITS(0), .SIGNED(0)) u_uns (
        .clk(clk), .rst_n(rst_n), .start_i(st[0]), .scale_i(sc[0]), .matrix_i(mat0),
        .out_matrix_o(out0), .busy_o(busy[0]), .done_o(done[0]), .div_zero_o(dz[0]), .ovf_o(ov[0]));

    scalar_divide_mat_seq #(.SIZE_A(2), .SIZE_B(2), .N_BITS(8), .FRAC_BITS(0), .SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .start_i(st[1]), .scale_i(sc[1]), .matrix_i(mat1),
        .out_matrix_o(out1), .busy_o(busy[1]), .done_o(done[1]), .div_zero_o(dz[1]), .ovf_o(ov[1]));

    scalar_divide_mat_seq #(.SIZE_A(2), .SIZE_B(2), .N_BITS(8), .FRAC_BITS(4), .SIGNED(0)) u_frac (
        .clk(clk), .rst_n(rst_n), .start_i(st[2]), .scale_i(sc[2]), .matrix_i(mat2),
        .out_matrix_o(out2), .busy_o(busy[2]), .done_o(done[2]), .div_zero_o(dz[2]), .ovf_o(ov[2]));

    // Model state per instance: m_t = clock edges since the accepting edge.
    int         m_t    [3];
    bit         m_seen [3];
    bit         m_zero [3];
    logic [7:0] m_res  [3][4];
    bit         m_sat  [3][4];

    function automatic int qk(input int k);
        return (k == 2) ? 12 : 8;
    endfunction

    function automatic bit sgn(input int k);
        return k == 1;
    endfunction

    function automatic int frc(input int k);
        return (k == 2) ? 4 : 0;
    endfunction

    function automatic int lat(input int k);
        return m_zero[k] ? 0 : E * (qk(k) + 1);
    endfunction

    function automatic logic [7:0] getm(input int k, input int e);
        case (k)
            0:       return mat0[e / 2][e % 2];
            1:       return mat1[e / 2][e % 2];
            default: return mat2[e / 2][e % 2];
        endcase
    endfunction

    function automatic logic [7:0] getout(input int k, input int e);
        case (k)
            0:       return out0[e / 2][e % 2];
            1:       return out1[e / 2][e % 2];
            default: return out2[e / 2][e % 2];
        endcase
    endfunction

    function automatic void model_elem(input int k, input logic [7:0] a, input logic [7:0] s,
                                       output logic [7:0] r, output bit sat);
        longint av, sv, num, den, q, res, hi, lo;
        hi  = sgn(k) ? 127 : 255;
        lo  = sgn(k) ? -128 : 0;
        sat = 1'b0;
        if (s == 8'd0) begin
            r = hi[7:0];
            return;
        end
        av  = sgn(k) ? longint'($signed(a)) : longint'(a);
        sv  = sgn(k) ? longint'($signed(s)) : longint'(s);
        num = av * (longint'(1) << frc(k));
        den = (sv < 0) ? -sv : sv;
        q   = ((num < 0) ? -num : num) / den;
`ifdef SCALAR_DIV_ROUND_NEAREST_EN
        if (2 * (((num < 0) ? -num : num) % den) >= den) q = q + 1;
`endif
        res = ((num < 0) != (sv < 0)) ? -q : q;
        if (res > hi) begin
            res = hi;
            sat = 1'b1;
        end
        if (res < lo) begin
            res = lo;
            sat = 1'b1;
        end
        r = res[7:0];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_seen[k] = 1'b0;
                m_t[k]    = 0;
                m_zero[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (st[k] && (!m_seen[k] || m_t[k] >= lat(k) + 1)) begin
                    m_seen[k] = 1'b1;
                    m_t[k]    = 0;
                    m_zero[k] = (sc[k] == 8'd0);
                    for (int e = 0; e < E; e++) begin
                        model_elem(k, getm(k, e), sc[k], m_res[k][e], m_sat[k][e]);
                    end
                end else if (m_seen[k] && m_t[k] < 1000000) begin
                    m_t[k]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                bit         wr;
                bit         ovf_e;
                logic [7:0] oe;
                ovf_e = 1'b0;
                for (int e = 0; e < E; e++) begin
                    wr = m_seen[k] && (m_zero[k] || m_t[k] >= (e + 1) * (qk(k) + 1));
                    oe = wr ? m_res[k][e] : 8'd0;
                    if (wr && m_sat[k][e]) ovf_e = 1'b1;
                    chk($sformatf("model u%0d out[%0d]", k, e), getout(k, e), oe);
                end
                chk($sformatf("model u%0d busy", k), busy[k],
                    m_seen[k] && !m_zero[k] && m_t[k] <= lat(k) - 1);
                chk($sformatf("model u%0d done", k), done[k], m_seen[k] && m_t[k] == lat(k));
                chk($sformatf("model u%0d div_zero", k), dz[k], m_seen[k] && m_zero[k]);
                chk($sformatf("model u%0d ovf", k), ov[k], ovf_e);
            end
        end
    end

    task automatic setm(input int k, input logic [7:0] a0, a1, a2, a3);
        case (k)
            0: begin mat0[0][0] = a0; mat0[0][1] = a1; mat0[1][0] = a2; mat0[1][1] = a3; end
            1: begin mat1[0][0] = a0; mat1[0][1] = a1; mat1[1][0] = a2; mat1[1][1] = a3; end
            default: begin mat2[0][0] = a0; mat2[0][1] = a1; mat2[1][0] = a2; mat2[1][1] = a3; end
        endcase
    endtask

    task automatic go(input int k, input logic [7:0] s, input logic [7:0] a0, a1, a2, a3);
        @(posedge clk);
        #1;
        sc[k] = s;
        setm(k, a0, a1, a2, a3);
        st[k] = 1'b1;
        @(posedge clk);
        #1;
        st[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget, output int n, output int nbusy);
        n     = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy[k]) nbusy++;
        end while (!done[k] && n < budget);
        if (!done[k]) chk($sformatf("u%0d done within budget", k), done[k], 1);
    endtask

    task automatic lit(input int k, input string nm, input int e0, e1, e2, e3);
        int ex [4];
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        for (int e = 0; e < E; e++) begin
            chk($sformatf("%s out[%0d]", nm, e), getout(k, e), ex[e]);
        end
    endtask

    initial begin
        int n, nb, ndone;
        for (int k = 0; k < 3; k++) begin
            st[k] = 1'b0;
            sc[k] = 8'd0;
            setm(k, 8'd0, 8'd0, 8'd0, 8'd0);
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset u%0d busy", k), busy[k], 0);
            chk($sformatf("reset u%0d done", k), done[k], 0);
            chk($sformatf("reset u%0d div_zero", k), dz[k], 0);
            chk($sformatf("reset u%0d ovf", k), ov[k], 0);
        end
        lit(0, "reset u0", 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Unsigned basic run
        go(0, 8'd5, 8'd10, 8'd20, 8'd30, 8'd255);
        wait_done(0, 200, n, nb);
        chk("t1 done latency", n, 37);
        chk("t1 busy cycles", nb, 36);
        lit(0, "t1", 2, 4, 6, 51);
        chk("t1 ovf", ov[0], 0);
        chk("t1 div_zero", dz[0], 0);

        // Zero scale, then recovery
        go(0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4);
        wait_done(0, 200, n, nb);
        chk("t2 done latency", n, 1);
        lit(0, "t2 zero", 255, 255, 255, 255);
        chk("t2 div_zero", dz[0], 1);
        go(0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd4);
        wait_done(0, 200, n, nb);
        chk("t2b done latency", n, 37);
        lit(0, "t2b", 1, 2, 3, 4);
        chk("t2b div_zero", dz[0], 0);

        // Signed
        go(1, 8'd2, 8'hF9, 8'h07, 8'h80, 8'h7F);
        wait_done(1, 200, n, nb);
        chk("t3 done latency", n, 37);
`ifdef SCALAR_DIV_ROUND_NEAREST_EN
        lit(1, "t3 round", 8'hFC, 8'h04, 8'hC0, 8'h40);
`else
        lit(1, "t3 trunc", 8'hFD, 8'h03, 8'hC0, 8'h3F);
`endif
        chk("t3 ovf", ov[1], 0);
        go(1, 8'hFF, 8'h80, 8'h06, 8'hFA, 8'h00);
        wait_done(1, 200, n, nb);
        lit(1, "t3b", 8'h7F, 8'hFA, 8'h06, 8'h00);
        chk("t3b ovf", ov[1], 1);

        // Fractional output with saturation
        go(2, 8'd2, 8'd3, 8'd1, 8'd200, 8'd0);
        wait_done(2, 300, n, nb);
        chk("t4 done latency", n, 53);
        lit(2, "t4", 8'h18, 8'h08, 8'hFF, 8'h00);
        chk("t4 ovf", ov[2], 1);

        // Reset mid-run on element 2
        go(0, 8'd3, 8'd9, 8'd12, 8'd15, 8'd30);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 busy after reset", busy[0], 0);
        chk("t5 done after reset", done[0], 0);
        chk("t5 u2 ovf after reset", ov[2], 0);
        chk("t5 u1 out after reset", getout(1, 0), 0);
        lit(0, "t5 reset", 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        go(0, 8'd3, 8'd9, 8'd12, 8'd15, 8'd30);
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done[0]) begin
                ndone++;
                lit(0, "t5", 3, 4, 5, 10);
            end
            st[0] = (i == 5 || i == 20 || i == 30);
        end
        st[0] = 1'b0;
        chk("t5 done count", ndone, 1);

        // Continuous start
        @(posedge clk);
        #1;
        sc[0] = 8'd7;
        setm(0, 8'd100, 8'd50, 8'd25, 8'd7);
        st[0] = 1'b1;
        for (int r = 0; r < 3; r++) begin
            wait_done(0, 200, n, nb);
            chk($sformatf("t6 done interval %0d", r), n, 38);
            lit(0, "t6", 14, 7, 3, 1);
        end
        st[0] = 1'b0;
        repeat (45) @(negedge clk);
        chk("t6 idle after release", busy[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
